// File: rtl/ws2812_line_encoder.sv
// WS2812 single-wire line encoder: pulls bits from frame_transmitter and emits high/low pulse pairs plus a latch period.
// Optional build macro WS2812_DOUT_INV_EN inverts led_dout for boards with an inverting level shifter.
module ws2812_line_encoder #(
    parameter int unsigned T0H_CYCLES   = 10,
    parameter int unsigned T1H_CYCLES   = 20,
    parameter int unsigned BIT_CYCLES   = 31,
    parameter int unsigned RESET_CYCLES = 7500
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    input  logic bit_to_transmit,
    input  logic all_bits_shifted,
    input  logic new_frames_set_rqst,
    output logic new_bit_rqst,
    output logic new_frame_rqst,
    output logic led_dout,
    output logic busy,
    output logic done
);

    localparam int unsigned CW = $clog2(RESET_CYCLES + 1);

    localparam logic [CW-1:0] T0H_LAST   = CW'(T0H_CYCLES - 1);
    localparam logic [CW-1:0] T1H_LAST   = CW'(T1H_CYCLES - 1);
    localparam logic [CW-1:0] L0_LAST    = CW'(BIT_CYCLES - 2 - T0H_CYCLES);
    localparam logic [CW-1:0] L1_LAST    = CW'(BIT_CYCLES - 2 - T1H_CYCLES);
    localparam logic [CW-1:0] RESET_LAST = CW'(RESET_CYCLES - 1);

`ifdef WS2812_DOUT_INV_EN
    localparam logic DOUT_INV = 1'b1;
`else
    localparam logic DOUT_INV = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH      = 3'd1,
        WAIT_FRAME = 3'd2,
        HIGH       = 3'd3,
        LOW        = 3'd4,
        LATCH      = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bit_q, bit_d;
    logic          new_bit_rqst_q, new_bit_rqst_d;
    logic          new_frame_rqst_q, new_frame_rqst_d;
    logic          led_dout_q, led_dout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fetch_entry_s;

    // Next-state, shared counter reload and registered output computation
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        bit_d            = bit_q;
        fetch_entry_s    = 1'b0;
        new_bit_rqst_d   = 1'b0;
        new_frame_rqst_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = FETCH;
                    cnt_d         = '0;
                    fetch_entry_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            // The FETCH outcome was decided on entry, so the request flops already encode it.
            FETCH: begin
                if (new_bit_rqst_q) begin
                    state_d = HIGH;
                    cnt_d   = bit_q ? T1H_LAST : T0H_LAST;
                end else if (new_frame_rqst_q) begin
                    state_d = WAIT_FRAME;
                    cnt_d   = '0;
                end else begin
                    state_d = LATCH;
                    cnt_d   = RESET_LAST;
                end
            end
            WAIT_FRAME: begin
                state_d       = FETCH;
                cnt_d         = '0;
                fetch_entry_s = 1'b1;
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    state_d = LOW;
                    cnt_d   = bit_q ? L1_LAST : L0_LAST;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    state_d       = FETCH;
                    cnt_d         = '0;
                    fetch_entry_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            LATCH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Evaluate the FETCH priority on the entering edge so the pulses are registered yet land in FETCH.
        if (fetch_entry_s) begin
            if (new_frames_set_rqst) begin
                new_bit_rqst_d   = 1'b0;
                new_frame_rqst_d = 1'b0;
            end else if (all_bits_shifted) begin
                new_frame_rqst_d = 1'b1;
            end else begin
                new_bit_rqst_d = 1'b1;
                bit_d          = bit_to_transmit;
            end
        end else begin
            new_bit_rqst_d   = 1'b0;
            new_frame_rqst_d = 1'b0;
        end

        led_dout_d = (state_d == HIGH) ^ DOUT_INV;
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == LATCH) && (cnt_d == '0);
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            bit_q            <= 1'b0;
            new_bit_rqst_q   <= 1'b0;
            new_frame_rqst_q <= 1'b0;
            led_dout_q       <= DOUT_INV;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            bit_q            <= bit_d;
            new_bit_rqst_q   <= new_bit_rqst_d;
            new_frame_rqst_q <= new_frame_rqst_d;
            led_dout_q       <= led_dout_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
        end
    end

    assign new_bit_rqst   = new_bit_rqst_q;
    assign new_frame_rqst = new_frame_rqst_q;
    assign led_dout       = led_dout_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule
